// File: rtl/booth_mac_ctrl_pkg.sv
// Shared constants and FSM encoding for the Booth multiply-accumulate sequencer.
// Operand and product widths are fixed by the 4-bit Booth multiplier it drives.
package booth_mac_ctrl_pkg;

    localparam int OP_W        = 4;
    localparam int PROD_W      = 8;
    localparam int ACC_W_DEF   = 12;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/booth_mac_ctrl_if.sv
// Operand input, multiplier side-channel and result output of the MAC sequencer.
// slave is the controller's view; master is the surrounding environment's view.
interface booth_mac_ctrl_if
    import booth_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_mplier;
    logic [OP_W-1:0]   in_mcand;
    logic              in_last;

    logic              mul_start;
    logic [OP_W-1:0]   mul_multiplier;
    logic [OP_W-1:0]   mul_multiplicand;
    logic [PROD_W-1:0] mul_product;
    logic              mul_finish;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;
    logic              out_err;

    modport slave (
        input  in_valid, in_mplier, in_mcand, in_last,
        input  mul_product, mul_finish, out_ready,
        output in_ready, mul_start, mul_multiplier, mul_multiplicand,
        output out_valid, out_acc, out_count, out_sat, out_err
    );

    modport master (
        output in_valid, in_mplier, in_mcand, in_last,
        output mul_product, mul_finish, out_ready,
        input  in_ready, mul_start, mul_multiplier, mul_multiplicand,
        input  out_valid, out_acc, out_count, out_sat, out_err
    );

endinterface

// File: rtl/booth_mac_ctrl_sat_add_signed.sv
// Combinational signed accumulator + sign-extended product adder with clamping.
// One guard bit is enough: the two top bits of the wide sum differ exactly on overflow.
module sat_add_signed
    import booth_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;

    assign wide = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
    assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

    always_comb begin
        sum = wide[ACC_W-1:0];
        if (ovf) begin
            sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/booth_mac_ctrl.sv
// Sequences operand pairs through the external Booth multiplier and accumulates a
// saturating dot product, presenting it downstream at the end of each burst.
module booth_mac_ctrl
    import booth_mac_ctrl_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_mac_ctrl_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t            state_reg,  state_next;
    logic [OP_W-1:0]   mplier_reg, mplier_next;
    logic [OP_W-1:0]   mcand_reg,  mcand_next;
    logic              last_reg,   last_next;
    logic [PROD_W-1:0] prod_reg,   prod_next;
    logic [TMR_W-1:0]  timer_reg,  timer_next;
    logic [ACC_W-1:0]  acc_reg,    acc_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic              sat_reg,    sat_next;
    logic              err_reg,    err_next;

    logic [ACC_W-1:0]  sum;
    logic              ovf;

    sat_add_signed #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc_reg),
        .b   (prod_reg),
        .sum (sum),
        .ovf (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            mplier_reg <= '0;
            mcand_reg  <= '0;
            last_reg   <= 1'b0;
            prod_reg   <= '0;
            timer_reg  <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sat_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mplier_reg <= mplier_next;
            mcand_reg  <= mcand_next;
            last_reg   <= last_next;
            prod_reg   <= prod_next;
            timer_reg  <= timer_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            sat_reg    <= sat_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mplier_next = mplier_reg;
        mcand_next  = mcand_reg;
        last_next   = last_reg;
        prod_next   = prod_reg;
        timer_next  = timer_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        sat_next    = sat_reg;
        err_next    = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mplier_next = bus.in_mplier;
                    mcand_next  = bus.in_mcand;
                    last_next   = bus.in_last;
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_next = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                timer_next = timer_reg + TMR_W'(1);
                // The multiplier has no reset, so its finish level is stale in the first WAIT cycle.
                if ((timer_reg != '0) && bus.mul_finish) begin
                    prod_next  = bus.mul_product;
                    state_next = ST_ACCUM;
                end else if (timer_reg == TMR_LAST) begin
                    prod_next  = '0;
                    err_next   = 1'b1;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_next   = sum;
                sat_next   = sat_reg | ovf;
                cnt_next   = cnt_reg + CNT_W'(1);
                state_next = last_reg ? ST_OUT : ST_IDLE;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                    err_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready         = (state_reg == ST_IDLE);
    assign bus.mul_start        = (state_reg == ST_ISSUE);
    assign bus.mul_multiplier   = mplier_reg;
    assign bus.mul_multiplicand = mcand_reg;
    assign bus.out_valid        = (state_reg == ST_OUT);
    assign bus.out_acc          = acc_reg;
    assign bus.out_count        = cnt_reg;
    assign bus.out_sat          = sat_reg;
    assign bus.out_err          = err_reg;

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Bench for booth_mac_ctrl: two lockstep instances (ACC_W=12 and ACC_W=8) each driven by a
// behavioural 4-cycle Booth multiplier model, checked against an arithmetic dot-product model.
module tb_booth_mac_ctrl;
    import booth_mac_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    booth_mac_ctrl_if #(.ACC_W(12), .CNT_W(8)) bus0 ();
    booth_mac_ctrl_if #(.ACC_W(8),  .CNT_W(8)) bus1 ();

    booth_mac_ctrl #(.ACC_W(12), .CNT_W(8), .TIMEOUT(15)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    booth_mac_ctrl #(.ACC_W(8),  .CNT_W(8), .TIMEOUT(15)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_mplier = bus0.in_mplier;
    assign bus1.in_mcand  = bus0.in_mcand;
    assign bus1.in_last   = bus0.in_last;
    assign bus1.out_ready = bus0.out_ready;

    // Multiplier models: product appears as a finish level 4 cycles after the start edge.
    bit         stub = 1'b0;
    logic       fin0 = 1'b0, fin1 = 1'b0, busy0 = 1'b0, busy1 = 1'b0;
    logic [7:0] prod0 = 8'd0, prod1 = 8'd0;
    int         mc0 = 0, mc1 = 0;
    assign bus0.mul_finish  = fin0;
    assign bus0.mul_product = prod0;
    assign bus1.mul_finish  = fin1;
    assign bus1.mul_product = prod1;

    function automatic logic [7:0] bmul(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[7:0];
    endfunction

    always @(posedge clk) begin
        if (bus0.mul_start) begin
            busy0 <= 1'b1; mc0 <= 3; fin0 <= 1'b0;
        end else if (busy0) begin
            if (mc0 == 0) begin
                busy0 <= 1'b0;
                if (!stub) begin
                    fin0  <= 1'b1;
                    prod0 <= bmul(bus0.mul_multiplier, bus0.mul_multiplicand);
                end
            end else mc0 <= mc0 - 1;
        end
    end

    always @(posedge clk) begin
        if (bus1.mul_start) begin
            busy1 <= 1'b1; mc1 <= 3; fin1 <= 1'b0;
        end else if (busy1) begin
            if (mc1 == 0) begin
                busy1 <= 1'b0;
                if (!stub) begin
                    fin1  <= 1'b1;
                    prod1 <= bmul(bus1.mul_multiplier, bus1.mul_multiplicand);
                end
            end else mc1 <= mc1 - 1;
        end
    end

    // Start-pulse and operand-stability monitors.
    int         cyc = 0, starts = 0;
    bit         prev_start = 1'b0, long_pulse = 1'b0, op_bad = 1'b0, track = 1'b0;
    logic [3:0] cap_mp = 4'd0, cap_mc = 4'd0;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        prev_start <= bus0.mul_start;
        if (bus0.mul_start) begin
            starts <= starts + 1;
            cap_mp <= bus0.mul_multiplier;
            cap_mc <= bus0.mul_multiplicand;
            track  <= 1'b1;
            if (prev_start) long_pulse <= 1'b1;
        end else if (!rst_n || bus0.in_ready) begin
            track <= 1'b0;
        end else if (track && (bus0.mul_multiplier != cap_mp || bus0.mul_multiplicand != cap_mc)) begin
            op_bad <= 1'b1;
        end
    end

    int checks = 0, passes = 0;
    int acc_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: plain signed arithmetic with clamping at each instance's width.
    int m_acc[2];
    bit m_sat[2];
    int m_cnt = 0;
    bit m_err = 1'b0;

    task automatic model_clear();
        m_acc[0] = 0; m_acc[1] = 0; m_sat[0] = 0; m_sat[1] = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_pair(input int mp, input int mc, input bit timed_out);
        int p, s, w, hi, lo;
        p = timed_out ? 0 : mp * mc;
        for (int k = 0; k < 2; k++) begin
            w  = (k == 0) ? 12 : 8;
            hi = (1 << (w - 1)) - 1;
            lo = -(1 << (w - 1));
            s  = m_acc[k] + p;
            if (s > hi) begin s = hi; m_sat[k] = 1; end
            else if (s < lo) begin s = lo; m_sat[k] = 1; end
            m_acc[k] = s;
        end
        m_cnt = (m_cnt + 1) % 256;
        if (timed_out) m_err = 1;
    endtask

    task automatic send_pair(input int mp, input int mc, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus0.in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("in_ready_wait", 0, 1);
        bus0.in_valid  = 1'b1;
        bus0.in_mplier = mp[3:0];
        bus0.in_mcand  = mc[3:0];
        bus0.in_last   = last;
        @(posedge clk); #1;
        acc_cyc       = cyc;
        bus0.in_valid = 1'b0;
        model_pair(mp, mc, stub);
    endtask

    task automatic get_result(input string tag, input bit pre_ready, input int hold, input int exp_lat);
        int n, lat;
        n = 0;
        bus0.out_ready = pre_ready;
        @(negedge clk);
        while (!bus0.out_valid && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, int'(bus0.out_valid), 1);
        lat = cyc - acc_cyc;
        if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_acc"},     int'($signed(bus0.out_acc)), m_acc[0]);
        chk({tag, "_count"},   int'(bus0.out_count), m_cnt);
        chk({tag, "_sat"},     int'(bus0.out_sat), int'(m_sat[0]));
        chk({tag, "_err"},     int'(bus0.out_err), int'(m_err));
        chk({tag, "_acc8"},    int'($signed(bus1.out_acc)), m_acc[1]);
        chk({tag, "_sat8"},    int'(bus1.out_sat), int'(m_sat[1]));
        $display("result %s: acc=%0d count=%0d sat=%0d err=%0d acc8=%0d sat8=%0d lat=%0d",
                 tag, $signed(bus0.out_acc), bus0.out_count, bus0.out_sat, bus0.out_err,
                 $signed(bus1.out_acc), bus1.out_sat, lat);
        repeat (hold) @(negedge clk);
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        model_clear();
        chk({tag, "_released"}, int'(bus0.out_valid), 0);
    endtask

    typedef struct {
        int mp;
        int mc;
        bit last;
        int exp_acc;
        int exp_cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int s0, len;
        tbl[0] = '{ 6, -6, 1'b1, -36, 1};
        tbl[1] = '{ 3,  2, 1'b0,   0, 0};
        tbl[2] = '{-4,  5, 1'b0,   0, 0};
        tbl[3] = '{ 7,  7, 1'b1,  35, 3};
        tbl[4] = '{-8, -8, 1'b1,  64, 1};
        tbl[5] = '{ 7, -8, 1'b1, -56, 1};
        tbl[6] = '{-1, -1, 1'b1,   1, 1};

        bus0.in_valid = 0; bus0.in_mplier = 0; bus0.in_mcand = 0; bus0.in_last = 0; bus0.out_ready = 0;
        model_clear();
        #2 rst_n = 1'b0;
        #10;
        chk("rst_in_ready",  int'(bus0.in_ready), 1);
        chk("rst_mul_start", int'(bus0.mul_start), 0);
        chk("rst_out_valid", int'(bus0.out_valid), 0);
        chk("rst_out_acc",   int'(bus0.out_acc), 0);
        chk("rst_out_count", int'(bus0.out_count), 0);
        chk("rst_flags",     int'({bus0.out_sat, bus0.out_err}), 0);
        chk("rst_operands",  int'({bus0.mul_multiplier, bus0.mul_multiplicand}), 0);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven bursts.
        s0 = starts; len = 0;
        for (int i = 0; i < 7; i++) begin
            send_pair(tbl[i].mp, tbl[i].mc, tbl[i].last);
            len++;
            if (tbl[i].last) begin
                chk($sformatf("tbl%0d_acc_exp", i), m_acc[0], tbl[i].exp_acc);
                chk($sformatf("tbl%0d_cnt_exp", i), m_cnt, tbl[i].exp_cnt);
                get_result($sformatf("tbl%0d", i), 1'b0, 0, (len == 1) ? 7 : -1);
                chk($sformatf("tbl%0d_starts", i), starts - s0, len);
                s0 = starts; len = 0;
            end
        end

        // Positive saturation at 8 bits, then a fresh burst clears sat.
        for (int i = 0; i < 4; i++) send_pair(-8, -8, i == 3);
        get_result("satpos", 1'b1, 0, -1);
        chk("satpos_acc8_const", m_acc[1], 0);
        send_pair(1, 1, 1'b1);
        get_result("satclr", 1'b0, 2, 7);

        // Negative saturation at 8 bits.
        for (int i = 0; i < 3; i++) send_pair(7, -8, i == 2);
        get_result("satneg", 1'b0, 0, -1);

        // Back-pressure: result held stable for 10 cycles, pairs refused meanwhile.
        send_pair(2, 3, 1'b1);
        get_result("hold_pre", 1'b1, 0, 7);
        send_pair(-3, 3, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus0.out_valid && n < 100) begin @(negedge clk); n++; end
            bus0.in_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("hold%0d_acc", i), int'($signed(bus0.out_acc)), -9);
                chk($sformatf("hold%0d_rdy", i), int'({bus0.out_valid, bus0.in_ready}), 2);
                @(negedge clk);
            end
            bus0.in_valid  = 1'b0;
            bus0.out_ready = 1'b1;
            @(posedge clk); #1;
            bus0.out_ready = 1'b0;
            model_clear();
            chk("hold_done_idle", int'({bus0.out_valid, bus0.in_ready}), 1);
            chk("hold_done_acc", int'(bus0.out_acc), 0);
            $display("result hold: released after 10 cycles");
        end

        // Multiplier stub never finishes: timeout after 15 WAIT cycles.
        stub = 1'b1;
        send_pair(3, 3, 1'b1);
        get_result("timeout", 1'b0, 0, 17);
        stub = 1'b0;
        send_pair(2, 2, 1'b1);
        get_result("after_to", 1'b0, 0, 7);

        // Asynchronous reset during WAIT.
        send_pair(5, 5, 1'b0);
        send_pair(2, 2, 1'b1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_acc",   int'(bus0.out_acc), 0);
        chk("arst_count", int'(bus0.out_count), 0);
        chk("arst_outs",  int'({bus0.mul_start, bus0.out_valid, bus0.out_sat, bus0.out_err}), 0);
        chk("arst_ops",   int'({bus0.mul_multiplier, bus0.mul_multiplicand}), 0);
        $display("result arst: reset applied in WAIT");
        model_clear();
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        send_pair(1, -1, 1'b1);
        get_result("arst_fresh", 1'b0, 0, 7);

        // Randomized bursts against the model.
        for (int b = 0; b < 25; b++) begin
            int blen;
            blen = $urandom_range(1, 5);
            for (int i = 0; i < blen; i++)
                send_pair($urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, i == blen - 1);
            get_result($sformatf("rnd%0d", b), 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
        end

        chk("start_pulse_width", int'(long_pulse), 0);
        chk("mul_op_stable",     int'(op_bad), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got %0d, expected %0d", 1, 0);
        $fatal(1, "simulation time limit");
    end

endmodule
